// File: rtl/fragment_resolver_if.sv
// Main-memory read/write port between the fragment resolver (master) and memory (slave).
interface fragment_resolver_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic                  mem_rd_en;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [ADDR_WIDTH-1:0] mem_wr_addr;
    logic                  mem_wr_en;

    modport master (input mem_rd_data, output mem_rd_addr, mem_rd_en, mem_wr_data, mem_wr_addr, mem_wr_en);
    modport slave  (output mem_rd_data, input mem_rd_addr, mem_rd_en, mem_wr_data, mem_wr_addr, mem_wr_en);
endinterface

// File: rtl/fragment_resolver.sv
// Walks the rasteriser's fragment array, bounds/depth-tests each fragment and
// commits depth and colour to the framebuffer, one fragment in flight at a time.
module fragment_resolver #(
    parameter int DATA_WIDTH                       = 32,
    parameter int MAIN_MEM_ADDR_WIDTH              = 32,
    parameter int LOCAL_VERTEX_MEM_ADDR_WIDTH      = 4,
    parameter int MAIN_MEM_CYCLES_WAIT_FOR_RECIEVE = 1
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic                                   en,
    input  logic                                   start,
    output logic                                   done,
    output logic                                   ready,
    output logic                                   err,
    input  logic [MAIN_MEM_ADDR_WIDTH-1:0]         f_array_ptr,
    input  logic [MAIN_MEM_ADDR_WIDTH-1:0]         fb_ptr,
    input  logic [MAIN_MEM_ADDR_WIDTH-1:0]         zb_ptr,
    input  logic [15:0]                            num_frags,
    input  logic [LOCAL_VERTEX_MEM_ADDR_WIDTH-1:0] vertexSize,
    input  logic [31:0]                            res_reg,
    input  logic                                   depth_test_en,
    fragment_resolver_if.master                    mem,
    output logic [15:0]                            frags_written,
    output logic [15:0]                            frags_discarded
);
    localparam int AW  = MAIN_MEM_ADDR_WIDTH;
    localparam int DW  = DATA_WIDTH;
    localparam int VW  = LOCAL_VERTEX_MEM_ADDR_WIDTH;
    localparam int LAT = MAIN_MEM_CYCLES_WAIT_FOR_RECIEVE;

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_FETCH      = 4'd1;
    localparam logic [3:0] S_WAIT_FETCH = 4'd2;
    localparam logic [3:0] S_CHECK      = 4'd3;
    localparam logic [3:0] S_ZREAD      = 4'd4;
    localparam logic [3:0] S_ZWAIT      = 4'd5;
    localparam logic [3:0] S_WRITE_Z    = 4'd6;
    localparam logic [3:0] S_WRITE_C    = 4'd7;
    localparam logic [3:0] S_NEXT       = 4'd8;
    localparam logic [3:0] S_DONE       = 4'd9;

    logic [3:0]    state_q, state_d;
    logic [1:0]    fcnt_q, fcnt_d;
    logic [AW-1:0] base_q, base_d, fb_q, fb_d, zb_q, zb_d, pix_q, pix_d;
    logic [15:0]   num_q, num_d, idx_q, idx_d;
    logic [VW-1:0] vsize_q, vsize_d;
    logic [31:0]   res_q, res_d;
    logic          dte_q, dte_d, err_q, err_d;
    logic [DW-1:0] x_q, x_d, y_q, y_d, z_q, z_d, col_q, col_d;
    logic [15:0]   written_q, written_d, discarded_q, discarded_d;

    logic          rd_en, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] wr_data;

    // Each issued read carries a tag {valid, is_depth, word}; it emerges exactly when its data does.
    logic [3:0] tag_q [LAT];
    logic [3:0] tag_d;
    logic       ret_v, ret_z;
    logic [1:0] ret_idx;

    assign tag_d   = {rd_en, state_q == S_ZREAD, fcnt_q};
    assign ret_v   = tag_q[LAT-1][3];
    assign ret_z   = tag_q[LAT-1][2];
    assign ret_idx = tag_q[LAT-1][1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= tag_d;
            for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        base_d      = base_q;
        fb_d        = fb_q;
        zb_d        = zb_q;
        pix_d       = pix_q;
        num_d       = num_q;
        idx_d       = idx_q;
        vsize_d     = vsize_q;
        res_d       = res_q;
        dte_d       = dte_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        col_d       = col_q;
        written_d   = written_q;
        discarded_d = discarded_q;
        err_d       = 1'b0;

        if (ret_v && !ret_z) begin
            case (ret_idx)
                2'd0:    x_d   = mem.mem_rd_data;
                2'd1:    y_d   = mem.mem_rd_data;
                2'd2:    z_d   = mem.mem_rd_data;
                default: col_d = mem.mem_rd_data;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = f_array_ptr;
                    fb_d    = fb_ptr;
                    zb_d    = zb_ptr;
                    num_d   = num_frags;
                    vsize_d = vertexSize;
                    res_d   = res_reg;
                    dte_d   = depth_test_en;
                    if (vertexSize < VW'(3)) begin
                        err_d = 1'b1;
                    end else if (num_frags == 16'd0) begin
                        state_d = S_DONE;
                    end else begin
                        written_d   = '0;
                        discarded_d = '0;
                        idx_d       = '0;
                        fcnt_d      = '0;
                        state_d     = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                fcnt_d = fcnt_q + 2'd1;
                if (fcnt_q == 2'd3) state_d = S_WAIT_FETCH;
            end
            S_WAIT_FETCH: begin
                if (ret_v && !ret_z && ret_idx == 2'd3) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (x_q >= DW'(res_q[31:16]) || y_q >= DW'(res_q[15:0])) begin
                    discarded_d = sat_inc(discarded_q);
                    state_d     = S_NEXT;
                end else begin
                    pix_d   = AW'(y_q) * AW'(res_q[31:16]) + AW'(x_q);
                    state_d = dte_q ? S_ZREAD : S_WRITE_Z;
                end
            end
            S_ZREAD: state_d = S_ZWAIT;
            S_ZWAIT: begin
                // Strictly-less wins; an equal depth loses to the fragment already stored.
                if (ret_v && ret_z) begin
                    if (z_q < mem.mem_rd_data) begin
                        state_d = S_WRITE_Z;
                    end else begin
                        discarded_d = sat_inc(discarded_q);
                        state_d     = S_NEXT;
                    end
                end
            end
            S_WRITE_Z: state_d = S_WRITE_C;
            S_WRITE_C: begin
                written_d = sat_inc(written_q);
                state_d   = S_NEXT;
            end
            S_NEXT: begin
                if (idx_q + 16'd1 == num_q) begin
                    idx_d   = idx_q + 16'd1;
                    base_d  = base_q + AW'(vsize_q) + AW'(1);
                    state_d = S_DONE;
                end else if (en) begin
                    idx_d   = idx_q + 16'd1;
                    base_d  = base_q + AW'(vsize_q) + AW'(1);
                    fcnt_d  = '0;
                    state_d = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            fcnt_q      <= '0;
            base_q      <= '0;
            fb_q        <= '0;
            zb_q        <= '0;
            pix_q       <= '0;
            num_q       <= '0;
            idx_q       <= '0;
            vsize_q     <= '0;
            res_q       <= '0;
            dte_q       <= 1'b0;
            err_q       <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            col_q       <= '0;
            written_q   <= '0;
            discarded_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            base_q      <= base_d;
            fb_q        <= fb_d;
            zb_q        <= zb_d;
            pix_q       <= pix_d;
            num_q       <= num_d;
            idx_q       <= idx_d;
            vsize_q     <= vsize_d;
            res_q       <= res_d;
            dte_q       <= dte_d;
            err_q       <= err_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            col_q       <= col_d;
            written_q   <= written_d;
            discarded_q <= discarded_d;
        end
    end

    always_comb begin
        rd_en   = 1'b0;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        case (state_q)
            S_FETCH: begin
                rd_en   = 1'b1;
                rd_addr = base_q + AW'(fcnt_q);
            end
            S_ZREAD: begin
                rd_en   = 1'b1;
                rd_addr = zb_q + pix_q;
            end
            S_WRITE_Z: begin
                wr_en   = 1'b1;
                wr_addr = zb_q + pix_q;
                wr_data = z_q;
            end
            S_WRITE_C: begin
                wr_en   = 1'b1;
                wr_addr = fb_q + pix_q;
                wr_data = col_q;
            end
            default: ;
        endcase
    end

    assign mem.mem_rd_en    = rd_en;
    assign mem.mem_rd_addr  = rd_addr;
    assign mem.mem_wr_en    = wr_en;
    assign mem.mem_wr_addr  = wr_addr;
    assign mem.mem_wr_data  = wr_data;
    assign done             = (state_q == S_DONE) || err_q;
    assign ready            = (state_q == S_IDLE);
    assign err              = err_q;
    assign frags_written    = written_q;
    assign frags_discarded  = discarded_q;
endmodule

// File: tb/tb_fragment_resolver.sv
// Scoreboard bench: two resolvers (read latency 1 and 3) share one word-addressed memory model.
module tb_fragment_resolver;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        en;
    logic [1:0]  start;
    logic [31:0] f_array_ptr, fb_ptr, zb_ptr, res_reg;
    logic [15:0] num_frags;
    logic [3:0]  vertexSize;
    logic        depth_test_en;

    logic        done_w [2];
    logic        ready_w [2];
    logic        err_w [2];
    logic [15:0] written_w [2];
    logic [15:0] discarded_w [2];
    logic        rd_en_w [2];
    logic        wr_en_w [2];
    logic [31:0] rd_addr_w [2];
    logic [31:0] wr_addr_w [2];
    logic [31:0] wr_data_w [2];

    logic [31:0] mem [1024];
    logic        load_en;
    logic [9:0]  load_addr;
    logic [31:0] load_data;

    always @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
        for (int k = 0; k < 2; k++)
            if (wr_en_w[k]) mem[wr_addr_w[k][9:0]] <= wr_data_w[k];
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_unit
        localparam int LAT = (gi == 0) ? 1 : 3;
        fragment_resolver_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
        logic [31:0] pipe [LAT];

        // Read data is only meaningful on the exact return cycle; poison it otherwise.
        always @(posedge clk) begin
            pipe[0] <= bus.mem_rd_en ? mem[bus.mem_rd_addr[9:0]] : 32'hDEADBEEF;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign bus.mem_rd_data = pipe[LAT-1];
        assign rd_en_w[gi]     = bus.mem_rd_en;
        assign rd_addr_w[gi]   = bus.mem_rd_addr;
        assign wr_en_w[gi]     = bus.mem_wr_en;
        assign wr_addr_w[gi]   = bus.mem_wr_addr;
        assign wr_data_w[gi]   = bus.mem_wr_data;

        fragment_resolver #(.MAIN_MEM_CYCLES_WAIT_FOR_RECIEVE(LAT)) u_dut (
            .clk             (clk),
            .resetn          (resetn),
            .en              (en),
            .start           (start[gi]),
            .done            (done_w[gi]),
            .ready           (ready_w[gi]),
            .err             (err_w[gi]),
            .f_array_ptr     (f_array_ptr),
            .fb_ptr          (fb_ptr),
            .zb_ptr          (zb_ptr),
            .num_frags       (num_frags),
            .vertexSize      (vertexSize),
            .res_reg         (res_reg),
            .depth_test_en   (depth_test_en),
            .mem             (bus),
            .frags_written   (written_w[gi]),
            .frags_discarded (discarded_w[gi])
        );
    end

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t exp_q [$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_rd(input logic [31:0] a);
        exp_q.push_back('{wr: 1'b0, addr: a, data: 32'h0});
    endtask

    task automatic push_rd4(input logic [31:0] a);
        for (int i = 0; i < 4; i++) push_rd(a + 32'(i));
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back('{wr: 1'b1, addr: a, data: d});
    endtask

    task automatic monitor_txn(input int u, input logic wr, input logic [31:0] a, input logic [31:0] d);
        txn_t e;
        $display("u%0d %s addr=%h data=%h", u, wr ? "WR" : "RD", a, d);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_txn: got %s addr=%h data=%h, expected no traffic", wr ? "WR" : "RD", a, d);
        end else begin
            e = exp_q.pop_front();
            check("txn_kind", 32'(wr), 32'(e.wr));
            check("txn_addr", a, e.addr);
            if (wr) check("txn_data", d, e.data);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rd_en_w[k]) check("rd_wr_exclusive", 32'(wr_en_w[k]), 32'd0);
                if (wr_en_w[k])      monitor_txn(k, 1'b1, wr_addr_w[k], wr_data_w[k]);
                else if (rd_en_w[k]) monitor_txn(k, 1'b0, rd_addr_w[k], 32'h0);
            end
        end
    end

    task automatic poke(input logic [9:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    task automatic load_frag(input logic [9:0] a, input logic [31:0] x, input logic [31:0] y,
                             input logic [31:0] z, input logic [31:0] c);
        poke(a, x);
        poke(a + 10'd1, y);
        poke(a + 10'd2, z);
        poke(a + 10'd3, c);
    endtask

    task automatic pulse_start(input int u);
        start[u] = 1'b1;
        @(negedge clk);
        start[u] = 1'b0;
    endtask

    task automatic wait_done(input int u, input int budget, output int cyc);
        cyc = 0;
        while (!done_w[u] && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (!done_w[u]) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: unit %0d got no done, expected one within %0d cycles", u, budget);
        end
    endtask

    task automatic set_cfg(input logic [31:0] fa, input logic [15:0] nf, input logic [3:0] vs, input logic dte);
        f_array_ptr   = fa;
        num_frags     = nf;
        vertexSize    = vs;
        depth_test_en = dte;
    endtask

    // Basic single fragment (2,1) in a 4x4 target -> pixel 6.
    task automatic run_basic(input string tag);
        int cyc;
        set_cfg(32'h100, 16'd1, 4'd3, 1'b0);
        push_rd4(32'h100);
        push_wr(32'h306, 32'd5);
        push_wr(32'h206, 32'hAABBCCDD);
        pulse_start(0);
        check({tag, "_ready_busy"}, 32'(ready_w[0]), 32'd0);
        wait_done(0, 50, cyc);
        check({tag, "_cycles"}, 32'(cyc), 32'd9);
        @(negedge clk);
        check({tag, "_done_once"}, 32'(done_w[0]), 32'd0);
        check({tag, "_ready_after"}, 32'(ready_w[0]), 32'd1);
        check({tag, "_written"}, 32'(written_w[0]), 32'd1);
        check({tag, "_discarded"}, 32'(discarded_w[0]), 32'd0);
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation got stuck, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        resetn        = 1'b0;
        en            = 1'b1;
        start         = 2'b00;
        load_en       = 1'b0;
        load_addr     = '0;
        load_data     = '0;
        fb_ptr        = 32'h200;
        zb_ptr        = 32'h300;
        res_reg       = 32'h0004_0004;
        set_cfg(32'h0, 16'd0, 4'd3, 1'b0);
        repeat (2) @(negedge clk);

        load_frag(10'h100, 32'd2, 32'd1, 32'd5, 32'hAABBCCDD);
        load_frag(10'h140, 32'd1, 32'd1, 32'd9, 32'h11111111);
        load_frag(10'h144, 32'd1, 32'd1, 32'd3, 32'h22222222);
        load_frag(10'h148, 32'd1, 32'd1, 32'd3, 32'h33333333);
        poke(10'h305, 32'hFFFFFFFF);
        load_frag(10'h180, 32'd4, 32'd0, 32'd1, 32'h44444444);
        load_frag(10'h188, 32'd0, 32'd4, 32'd1, 32'h55555555);
        load_frag(10'h1C0, 32'd0, 32'd0, 32'd7, 32'hE0E0E0E0);
        load_frag(10'h1C4, 32'd3, 32'd3, 32'd8, 32'hE1E1E1E1);

        resetn = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_done", 32'(done_w[k]), 32'd0);
            check("rst_ready", 32'(ready_w[k]), 32'd1);
            check("rst_err", 32'(err_w[k]), 32'd0);
            check("rst_rd_en", 32'(rd_en_w[k]), 32'd0);
            check("rst_wr_en", 32'(wr_en_w[k]), 32'd0);
            check("rst_rd_addr", rd_addr_w[k], 32'd0);
            check("rst_wr_addr", wr_addr_w[k], 32'd0);
            check("rst_wr_data", wr_data_w[k], 32'd0);
            check("rst_written", 32'(written_w[k]), 32'd0);
            check("rst_discarded", 32'(discarded_w[k]), 32'd0);
        end

        run_basic("basic");

        // Same pixel 5 three times: z=9 and z=3 commit, the repeated z=3 ties and is dropped.
        set_cfg(32'h140, 16'd3, 4'd3, 1'b1);
        push_rd4(32'h140); push_rd(32'h305); push_wr(32'h305, 32'd9); push_wr(32'h205, 32'h11111111);
        push_rd4(32'h144); push_rd(32'h305); push_wr(32'h305, 32'd3); push_wr(32'h205, 32'h22222222);
        push_rd4(32'h148); push_rd(32'h305);
        pulse_start(0);
        wait_done(0, 100, cyc);
        check("depth_cycles", 32'(cyc), 32'd31);
        @(negedge clk);
        check("depth_written", 32'(written_w[0]), 32'd2);
        check("depth_discarded", 32'(discarded_w[0]), 32'd1);
        check("depth_pending", 32'(exp_q.size()), 32'd0);

        // Stride 8: second fragment fetched at base+8; both out of bounds, no writes.
        set_cfg(32'h180, 16'd2, 4'd7, 1'b1);
        push_rd4(32'h180);
        push_rd4(32'h188);
        pulse_start(0);
        wait_done(0, 100, cyc);
        check("bounds_cycles", 32'(cyc), 32'd14);
        @(negedge clk);
        check("bounds_written", 32'(written_w[0]), 32'd0);
        check("bounds_discarded", 32'(discarded_w[0]), 32'd2);
        check("bounds_pending", 32'(exp_q.size()), 32'd0);

        set_cfg(32'h100, 16'd0, 4'd3, 1'b0);
        pulse_start(0);
        check("zero_done", 32'(done_w[0]), 32'd1);
        check("zero_ready_in_done", 32'(ready_w[0]), 32'd0);
        check("zero_err", 32'(err_w[0]), 32'd0);
        @(negedge clk);
        check("zero_done_off", 32'(done_w[0]), 32'd0);
        check("zero_ready_back", 32'(ready_w[0]), 32'd1);

        set_cfg(32'h100, 16'd1, 4'd2, 1'b0);
        pulse_start(0);
        check("vs2_err", 32'(err_w[0]), 32'd1);
        check("vs2_done", 32'(done_w[0]), 32'd1);
        check("vs2_ready", 32'(ready_w[0]), 32'd1);
        @(negedge clk);
        check("vs2_err_off", 32'(err_w[0]), 32'd0);
        check("vs2_done_off", 32'(done_w[0]), 32'd0);
        check("degenerate_pending", 32'(exp_q.size()), 32'd0);

        // Latency 3, en dropped inside WAIT_FETCH of fragment 0: it must finish, then park in NEXT.
        set_cfg(32'h1C0, 16'd2, 4'd3, 1'b0);
        push_rd4(32'h1C0); push_wr(32'h300, 32'd7); push_wr(32'h200, 32'hE0E0E0E0);
        pulse_start(1);
        repeat (4) @(negedge clk);
        en = 1'b0;
        repeat (12) @(negedge clk);
        check("en_hold_done", 32'(done_w[1]), 32'd0);
        check("en_hold_ready", 32'(ready_w[1]), 32'd0);
        check("en_hold_written", 32'(written_w[1]), 32'd1);
        check("en_hold_pending", 32'(exp_q.size()), 32'd0);
        push_rd4(32'h1C4); push_wr(32'h30F, 32'd8); push_wr(32'h20F, 32'hE1E1E1E1);
        en = 1'b1;
        wait_done(1, 100, cyc);
        check("en_resume_cycles", 32'(cyc), 32'd12);
        @(negedge clk);
        check("en_written", 32'(written_w[1]), 32'd2);
        check("en_discarded", 32'(discarded_w[1]), 32'd0);
        check("en_pending", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset while the depth write is on the bus.
        set_cfg(32'h100, 16'd1, 4'd3, 1'b0);
        push_rd4(32'h100);
        push_wr(32'h306, 32'd5);
        pulse_start(0);
        for (int i = 0; i < 30 && !wr_en_w[0]; i++) @(negedge clk);
        check("rst_reach_write_z", 32'(wr_en_w[0]), 32'd1);
        #1;
        resetn = 1'b0;
        #1;
        check("rst_mid_wr_en", 32'(wr_en_w[0]), 32'd0);
        check("rst_mid_ready", 32'(ready_w[0]), 32'd1);
        check("rst_mid_discarded", 32'(discarded_w[0]), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("rst_post_ready", 32'(ready_w[0]), 32'd1);
        check("rst_post_pending", 32'(exp_q.size()), 32'd0);
        run_basic("after_reset");

        check("final_pending", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
